// File: rtl/pipe_pkg.sv
// Shared decode-to-execute definitions: ALU opcodes, control bundle and issue-stage states.
package pipe_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_EQ   = 4'b1010;
  localparam logic [3:0] ALU_NE   = 4'b1011;
  localparam logic [3:0] ALU_GE   = 4'b1100;

  typedef struct packed {
    logic alu_src;
    logic reg_write;
    logic mem_read;
    logic mem_write;
  } ctrl_t;

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } state_t;

endpackage

// File: rtl/fwd_select.sv
// Resolves one source operand against the EX/MEM and MEM/WB result buses; EX/MEM is younger and wins.
module fwd_select #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] i_idx,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [REG_ADDR_W-1:0] i_exmem_rd,
  input  logic                  i_exmem_we,
  input  logic [DATA_WIDTH-1:0] i_exmem_result,
  input  logic [REG_ADDR_W-1:0] i_memwb_rd,
  input  logic                  i_memwb_we,
  input  logic [DATA_WIDTH-1:0] i_memwb_result,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic w_hit_exmem;
  logic w_hit_memwb;

  // x0 is hardwired to zero, so a write to it must never be forwarded.
  assign w_hit_exmem = i_exmem_we && (i_exmem_rd != '0) && (i_exmem_rd == i_idx);
  assign w_hit_memwb = i_memwb_we && (i_memwb_rd != '0) && (i_memwb_rd == i_idx);

  assign o_data = w_hit_exmem ? i_exmem_result :
                  w_hit_memwb ? i_memwb_result : i_data;

endmodule

// File: rtl/ex_issue_stage.sv
// Decode-to-execute register feeding the ALU, with operand forwarding, load-use bubble and flush.
module ex_issue_stage
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int REG_ADDR_W    = 5,
  parameter int CNT_W         = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_rs1_data,
  input  logic [DATA_WIDTH-1:0]    in_rs2_data,
  input  logic [DATA_WIDTH-1:0]    in_imm,
  input  logic [REG_ADDR_W-1:0]    in_rs1,
  input  logic [REG_ADDR_W-1:0]    in_rs2,
  input  logic [REG_ADDR_W-1:0]    in_rd,
  input  logic                     in_alu_src,
  input  logic [OPCODE_LENGTH-1:0] in_alu_op,
  input  logic                     in_reg_write,
  input  logic                     in_mem_read,
  input  logic                     in_mem_write,
  input  logic                     flush,
  input  logic [REG_ADDR_W-1:0]    exmem_rd,
  input  logic                     exmem_reg_write,
  input  logic [DATA_WIDTH-1:0]    exmem_result,
  input  logic [REG_ADDR_W-1:0]    memwb_rd,
  input  logic                     memwb_reg_write,
  input  logic [DATA_WIDTH-1:0]    memwb_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    src_a,
  output logic [DATA_WIDTH-1:0]    src_b,
  output logic [OPCODE_LENGTH-1:0] operation,
  output logic [DATA_WIDTH-1:0]    store_data,
  output logic [REG_ADDR_W-1:0]    out_rd,
  output logic                     out_reg_write,
  output logic                     out_mem_read,
  output logic                     out_mem_write,
  output logic [CNT_W-1:0]         stall_count
);

  logic                     r_valid;
  ctrl_t                    r_ctrl;
  logic [OPCODE_LENGTH-1:0] r_alu_op;
  logic [REG_ADDR_W-1:0]    r_rs1, r_rs2, r_rd;
  logic [DATA_WIDTH-1:0]    r_rs1_data, r_rs2_data, r_imm;
  state_t                   r_state;
  logic [CNT_W-1:0]         r_stall_count;

  state_t                   w_state_nxt;
  logic                     w_bubble_enter;
  logic                     w_hz;
  logic                     w_up;
  logic [DATA_WIDTH-1:0]    w_rs1_fwd, w_rs2_fwd;

  fwd_select #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
    .i_idx(r_rs1), .i_data(r_rs1_data),
    .i_exmem_rd(exmem_rd), .i_exmem_we(exmem_reg_write), .i_exmem_result(exmem_result),
    .i_memwb_rd(memwb_rd), .i_memwb_we(memwb_reg_write), .i_memwb_result(memwb_result),
    .o_data(w_rs1_fwd)
  );

  fwd_select #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
    .i_idx(r_rs2), .i_data(r_rs2_data),
    .i_exmem_rd(exmem_rd), .i_exmem_we(exmem_reg_write), .i_exmem_result(exmem_result),
    .i_memwb_rd(memwb_rd), .i_memwb_we(memwb_reg_write), .i_memwb_result(memwb_result),
    .o_data(w_rs2_fwd)
  );

  // A held load whose destination the decode instruction reads cannot be forwarded in time.
  assign w_hz = r_valid && r_ctrl.mem_read && (r_rd != '0) && in_valid &&
                ((in_rs1 == r_rd) || (in_rs2 == r_rd));

  assign in_ready = !flush && (r_state == RUN) && !w_hz && (!r_valid || out_ready);
  assign w_up     = in_valid && in_ready;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt    = r_state;
    w_bubble_enter = 1'b0;
    if (flush) begin
      w_state_nxt = RUN;
    end else begin
      case (r_state)
        RUN: begin
          if (w_hz && out_ready) begin
            w_state_nxt    = BUBBLE;
            w_bubble_enter = 1'b1;
          end
        end
        BUBBLE:  w_state_nxt = RUN;
        default: w_state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: held data fields are cleared as well, so outputs are defined zeros, never X, after reset.
      r_valid       <= 1'b0;
      r_ctrl        <= '0;
      r_alu_op      <= '0;
      r_rs1         <= '0;
      r_rs2         <= '0;
      r_rd          <= '0;
      r_rs1_data    <= '0;
      r_rs2_data    <= '0;
      r_imm         <= '0;
      r_state       <= RUN;
      r_stall_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_bubble_enter && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + 1'b1;
      end
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_up) begin
        r_valid    <= 1'b1;
        r_ctrl     <= '{alu_src: in_alu_src, reg_write: in_reg_write,
                        mem_read: in_mem_read, mem_write: in_mem_write};
        r_alu_op   <= in_alu_op;
        r_rs1      <= in_rs1;
        r_rs2      <= in_rs2;
        r_rd       <= in_rd;
        r_rs1_data <= in_rs1_data;
        r_rs2_data <= in_rs2_data;
        r_imm      <= in_imm;
      end else if (out_valid && out_ready) begin
        r_valid <= 1'b0;
      end else if (r_valid) begin
        // Capture results that retire while stalled; they may be gone from the buses next cycle.
        r_rs1_data <= w_rs1_fwd;
        r_rs2_data <= w_rs2_fwd;
      end
    end
  end

  assign out_valid     = r_valid;
  assign src_a         = w_rs1_fwd;
  assign src_b         = r_ctrl.alu_src ? r_imm : w_rs2_fwd;
  assign store_data    = w_rs2_fwd;
  assign operation     = r_alu_op;
  assign out_rd        = r_rd;
  assign out_reg_write = r_ctrl.reg_write;
  assign out_mem_read  = r_ctrl.mem_read;
  assign out_mem_write = r_ctrl.mem_write;
  assign stall_count   = r_stall_count;

endmodule
